// File: rtl/prefetcher_issue.sv
// Stride prefetcher issue engine: learns a constant demand stride, then runs
// ahead of the demand stream by issuing block read requests to memory and
// posting a writeReq command to the data queue for each accepted request.
module prefetcher_issue #(
   parameter int ADDR_BITS            = 64,
   parameter int LOG_BLOCK_DATA_BYTES = 6,
   parameter int LOG_QUEUE_SIZE       = 6
) (
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      cpuReqValid,
   input  logic [ADDR_BITS-1:0]      cpuReqAddr,
   input  logic                      crs_enable,
   input  logic [LOG_QUEUE_SIZE:0]   crs_prefetchDepth,
   input  logic [LOG_QUEUE_SIZE:0]   crs_maxOutstanding,
   input  logic                      almostFull,
   input  logic [LOG_QUEUE_SIZE:0]   outstandingReqCnt,
   output logic                      arValid,
   input  logic                      arReady,
   output logic [ADDR_BITS-1:0]      arAddr,
   output logic [2:0]                qOpcode,
   output logic [ADDR_BITS-1:0]      qAddr,
   output logic                      strideLocked,
   output logic [ADDR_BITS-1:0]      stride,
   output logic [2:0]                o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TRAIN  = 3'd1,
      S_LOCKED = 3'd2,
      S_ISSUE  = 3'd3,
      S_DRAIN  = 3'd4
   } state_t;

   localparam logic [2:0] Q_NOP       = 3'd0;
   localparam logic [2:0] Q_WRITE_REQ = 3'd3;
   localparam logic [LOG_QUEUE_SIZE:0] CNT_ONE = {{LOG_QUEUE_SIZE{1'b0}}, 1'b1};
   // Offset bits inside a block; demand addresses are block aligned, so these are cleared.
   localparam logic [ADDR_BITS-1:0] BLOCK_MASK =
      {{(ADDR_BITS-LOG_BLOCK_DATA_BYTES){1'b0}}, {LOG_BLOCK_DATA_BYTES{1'b1}}};

   state_t                    r_state;
   logic [ADDR_BITS-1:0]      r_last_addr;
   logic [ADDR_BITS-1:0]      r_stride;
   logic [1:0]                r_conf;
   logic [ADDR_BITS-1:0]      r_demand_addr;
   logic [ADDR_BITS-1:0]      r_next_pf_addr;
   logic [LOG_QUEUE_SIZE:0]   r_issued_ahead;

   logic [ADDR_BITS-1:0]      w_req_addr;
   logic [ADDR_BITS-1:0]      w_delta;
   logic [ADDR_BITS-1:0]      w_next_demand;
   logic                      w_same_stride;
   logic [1:0]                w_conf_next;
   logic                      w_demand_hit;
   logic                      w_handshake;
   logic                      w_can_issue;
   logic                      w_issue_leave;

   // Read-request handshake: arValid/arAddr are held unchanged from the cycle
   // arValid rises until the rising edge where arValid && arReady; that edge
   // is the transfer, arValid falls, and the queue writeReq follows one cycle.
   assign w_handshake   = arValid && arReady;

   assign w_req_addr    = cpuReqAddr & ~BLOCK_MASK;
   assign w_delta       = w_req_addr - r_last_addr;
   assign w_next_demand = r_demand_addr + r_stride;
   assign w_same_stride = (w_delta == r_stride) && (w_delta != '0);
   assign w_conf_next   = w_same_stride ? (r_conf + 2'd1) : {1'b0, (w_delta != '0)};
   assign w_demand_hit  = (w_req_addr == r_demand_addr);
   assign w_can_issue   = crs_enable && !cpuReqValid && !almostFull &&
                          (r_issued_ahead < crs_prefetchDepth) &&
                          (outstandingReqCnt < crs_maxOutstanding);
   // An in-flight request must drain before retraining or disabling.
   assign w_issue_leave = !crs_enable || (cpuReqValid && !w_demand_hit);

   assign strideLocked  = (r_state == S_LOCKED) || (r_state == S_ISSUE);
   assign stride        = r_stride;
   assign o_dbg_state   = r_state;

   // Training, demand tracking, request issue and queue command generation.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state        <= S_IDLE;
         r_last_addr    <= '0;
         r_stride       <= '0;
         r_conf         <= '0;
         r_demand_addr  <= '0;
         r_next_pf_addr <= '0;
         r_issued_ahead <= '0;
         arValid        <= 1'b0;
         arAddr         <= '0;
         qOpcode        <= Q_NOP;
         qAddr          <= '0;
      end else begin
         qOpcode <= Q_NOP;
         if (w_handshake) begin
            arValid <= 1'b0;
            qOpcode <= Q_WRITE_REQ;
            qAddr   <= arAddr;
         end
         case (r_state)
            S_IDLE: begin
               if (cpuReqValid && crs_enable) begin
                  r_last_addr <= w_req_addr;
                  r_conf      <= '0;
                  r_state     <= S_TRAIN;
               end
            end
            S_TRAIN: begin
               if (!crs_enable) begin
                  r_state <= S_IDLE;
               end else if (cpuReqValid) begin
                  r_last_addr <= w_req_addr;
                  r_conf      <= w_conf_next;
                  if (!w_same_stride) r_stride <= w_delta;
                  if (w_conf_next == 2'd2) begin
                     // Locking implies w_delta equals the learned stride.
                     r_state        <= S_LOCKED;
                     r_demand_addr  <= w_req_addr + w_delta;
                     r_next_pf_addr <= w_req_addr + w_delta;
                     r_issued_ahead <= '0;
                  end
               end
            end
            S_LOCKED: begin
               if (!crs_enable) begin
                  r_state <= S_IDLE;
               end else if (cpuReqValid) begin
                  r_last_addr <= w_req_addr;
                  if (w_demand_hit) begin
                     r_demand_addr <= w_next_demand;
                     if (r_issued_ahead != '0) r_issued_ahead <= r_issued_ahead - CNT_ONE;
                     else                      r_next_pf_addr <= w_next_demand;
                  end else begin
                     r_stride <= w_delta;
                     r_conf   <= '0;
                     r_state  <= S_TRAIN;
                  end
               end else if (w_can_issue) begin
                  arValid        <= 1'b1;
                  arAddr         <= r_next_pf_addr;
                  r_next_pf_addr <= r_next_pf_addr + r_stride;
                  r_issued_ahead <= r_issued_ahead + CNT_ONE;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (cpuReqValid) begin
                  r_last_addr <= w_req_addr;
                  if (w_demand_hit) begin
                     r_demand_addr <= w_next_demand;
                     if (r_issued_ahead != '0) r_issued_ahead <= r_issued_ahead - CNT_ONE;
                     else                      r_next_pf_addr <= w_next_demand;
                  end else begin
                     r_stride <= w_delta;
                  end
               end
               if (w_issue_leave) r_conf <= '0;
               if (w_handshake) begin
                  if (!w_issue_leave)  r_state <= S_LOCKED;
                  else if (crs_enable) r_state <= S_TRAIN;
                  else                 r_state <= S_IDLE;
               end else if (w_issue_leave) begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_handshake) r_state <= crs_enable ? S_TRAIN : S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
